// File: rtl/checkpoint_cycle_profiler.sv
// Multi-channel cycle profiler: each channel measures the cycles between a start
// and an end value on a firmware-driven checkpoint marker bus, with optional timeout.
module checkpoint_cycle_profiler #(
    parameter int MARK_W = 16,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [MARK_W-1:0] mark_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic              cfg_en_i,
    input  logic [MARK_W-1:0] cfg_start_i,
    input  logic [MARK_W-1:0] cfg_end_i,
    input  logic [CNT_W-1:0]  timeout_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [2:0]        rd_state_o,
    output logic [NUM_CH-1:0] done_o,
    output logic [NUM_CH-1:0] tmo_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_TMO   = 3'd4
    } state_t;

    logic [MARK_W-1:0]             mark_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  count_all;
    logic [NUM_CH-1:0][2:0]        state_all;
    logic [CNT_W-1:0]              rd_cnt_next;
    logic [2:0]                    rd_state_next;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mark_q <= '0;
        end else begin
            mark_q <= mark_i;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t            state_reg;
        logic [CNT_W-1:0]  count_reg;
        logic [MARK_W-1:0] start_reg;
        logic [MARK_W-1:0] end_reg;
        logic              done_reg;
        logic              tmo_reg;
        logic              cfg_hit;
        logic [CNT_W:0]    count_inc;
        logic [CNT_W-1:0]  count_sat;
        logic              hit_tmo;

        // Out-of-range channel numbers match no channel and are dropped here.
        assign cfg_hit   = cfg_we_i && (cfg_ch_i == CH_W'(gi));
        assign count_inc = {1'b0, count_reg} + (CNT_W+1)'(1);
        assign count_sat = count_inc[CNT_W] ? count_reg : count_inc[CNT_W-1:0];
        assign hit_tmo   = (timeout_i != '0) && (count_inc == {1'b0, timeout_i});

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                state_reg <= ST_IDLE;
                count_reg <= '0;
                start_reg <= '0;
                end_reg   <= '0;
                done_reg  <= 1'b0;
                tmo_reg   <= 1'b0;
            end else if (cfg_hit) begin
                start_reg <= cfg_start_i;
                end_reg   <= cfg_end_i;
                count_reg <= '0;
                done_reg  <= 1'b0;
                tmo_reg   <= 1'b0;
                state_reg <= cfg_en_i ? ST_ARMED : ST_IDLE;
            end else begin
                case (state_reg)
                    ST_ARMED: begin
                        if (mark_q == start_reg) begin
                            state_reg <= ST_RUN;
                            count_reg <= '0;
                        end
                    end
                    ST_RUN: begin
                        // End marker beats a timeout landing on the same cycle.
                        if (mark_q == end_reg) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            count_reg <= count_sat;
                        end else if (hit_tmo) begin
                            state_reg <= ST_TMO;
                            tmo_reg   <= 1'b1;
                            count_reg <= timeout_i;
                        end else begin
                            count_reg <= count_sat;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign count_all[gi] = count_reg;
        assign state_all[gi] = state_reg;
        assign done_o[gi]    = done_reg;
        assign tmo_o[gi]     = tmo_reg;
    end

    always_comb begin
        rd_cnt_next   = '0;
        rd_state_next = 3'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_i == CH_W'(c)) begin
                rd_cnt_next   = count_all[c];
                rd_state_next = state_all[c];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_cnt_o   <= '0;
            rd_state_o <= 3'd0;
        end else begin
            rd_cnt_o   <= rd_cnt_next;
            rd_state_o <= rd_state_next;
        end
    end

endmodule

// File: doc/checkpoint_cycle_profiler.md
CHECKPOINT_CYCLE_PROFILER -- requirements
Module: checkpoint_cycle_profiler

Interface
REQ-001 SHALL have parameter MARK_W, default 16: width of the checkpoint marker bus.
REQ-002 SHALL have parameter NUM_CH, default 4, range 1..16: number of independent measurement channels.
REQ-003 SHALL have parameter CNT_W, default 32: width of each channel cycle counter and of the timeout limit.
REQ-004 SHALL have port wb_clk_i, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port mark_i, input, MARK_W: checkpoint marker bus written by firmware (GPIO checkbits).
REQ-007 SHALL have port cfg_we_i, input, 1: config write strobe, one cycle.
REQ-008 SHALL have port cfg_ch_i, input, CH_W=max(1,clog2(NUM_CH)): channel selected for a config write.
REQ-009 SHALL have port cfg_en_i, input, 1: channel enable written with the config.
REQ-010 SHALL have ports cfg_start_i and cfg_end_i, input, MARK_W each: start and end marker values.
REQ-011 SHALL have port timeout_i, input, CNT_W: global cycle limit; 0 disables the timeout.
REQ-012 SHALL have port rd_ch_i, input, CH_W: channel selected for readback.
REQ-013 SHALL have port rd_cnt_o, output, CNT_W: registered count of channel rd_ch_i.
REQ-014 SHALL have port rd_state_o, output, 3: registered state code of channel rd_ch_i.
REQ-015 SHALL have ports done_o and tmo_o, output, NUM_CH each: per-channel done and timeout flags.

Function
REQ-016 SHALL register mark_i once into mark_q; every marker comparison SHALL use mark_q.
REQ-017 Each channel SHALL run its own FSM: IDLE=0, ARMED=1, RUN=2, DONE=3, TMO=4.
REQ-018 IDLE SHALL hold count and flags; the channel leaves IDLE only on a config write.
REQ-019 ARMED -> RUN in the cycle mark_q equals that channel's start marker; count SHALL load 0 in the same edge.
REQ-020 In RUN, count SHALL increment by 1 every cycle, including the cycle the end marker is seen.
  - Resulting count = cycles between start observation and end observation.
  - Example: start seen at cycle t, end at t+N -> count = N.
REQ-021 RUN -> DONE when mark_q equals the end marker; count SHALL freeze and done_o[ch] SHALL go to 1.
REQ-022 RUN -> TMO when timeout_i != 0 and the incremented count would reach timeout_i.
  - count SHALL freeze at timeout_i and tmo_o[ch] SHALL go to 1.
  - If the end marker and the timeout occur in the same cycle, DONE SHALL win.
REQ-023 DONE and TMO SHALL be sticky until the next config write to that channel.
REQ-024 The counter SHALL saturate at 2^CNT_W-1 and never wrap; the state stays RUN.
REQ-025 Equal start and end markers SHALL be legal.
  - The start match moves the channel to RUN; the end marker is checked only from the next cycle.
REQ-026 A config write to channel c at any state SHALL take effect at the next edge:
  - store the start and end markers;
  - clear count, done_o[c] and tmo_o[c];
  - go to ARMED if cfg_en_i=1, else IDLE.
  - A write in RUN aborts the measurement in progress.
REQ-027 A config write with cfg_ch_i >= NUM_CH SHALL be ignored.
REQ-028 A config write and a marker match on the same channel in the same cycle: the config write SHALL win.
REQ-029 All channels SHALL evaluate the same mark_q in parallel; one marker may start or end several channels at once.
REQ-030 rd_cnt_o and rd_state_o SHALL reflect channel rd_ch_i with 1-cycle latency; rd_ch_i >= NUM_CH SHALL read 0.

Reset
REQ-031 While wb_rst_i=1 at a rising edge, all of the following SHALL be 0:
  - every channel state (IDLE), count, start and end markers;
  - mark_q, done_o, tmo_o, rd_cnt_o, rd_state_o.
REQ-032 Reset SHALL override a simultaneous config write; the first config write SHALL be accepted on the first edge after wb_rst_i falls.

Verification
REQ-033 Basic interval: ch0 start=0xAB50, end=0x2371, enabled; drive 0xAB50, then 0x2371 100 cycles later -> done_o[0]=1, rd_cnt_o=100, rd_state_o=3.
REQ-034 Chained channels: ch1 0x2371->0xBF5A, ch2 0xBF5A->0x0050, ch3 0xAB50->0xAB51.
  - Drive the sequence 0xAB50, 0x2371, 0xBF5A, 0x0050, 0xAB51 at cycles 0, 40, 70, 120, 130.
  - Expect counts ch1=30, ch2=50, ch3=130, all done_o set.
REQ-035 Timeout: timeout_i=20; start seen and end never driven -> tmo_o=1 at exactly 20 cycles, rd_cnt_o=20, rd_state_o=4. End on that same cycle -> DONE instead.
REQ-036 Abort: reconfigure ch0 with cfg_en_i=0 while in RUN at count 15 -> next cycle state IDLE, count 0; later markers ignored.
REQ-037 Reset mid-RUN with a simultaneous cfg_we_i -> all outputs 0, all channels IDLE; no channel starts until reconfigured.
REQ-038 Edge cases: equal start and end markers give count = cycles to the next occurrence; out-of-range cfg_ch_i and rd_ch_i are ignored and read 0; CNT_W=4 saturates at 15.
